// File: rtl/mbox_cyc_responder_if.sv
// EBOX-to-MBOX cycle bus plus the backing-memory request/ack port, bundled
// so the responder and its environment share one connection.
interface mbox_cyc_responder_if #(
    parameter int ADDR_W = 23
);
    logic              MBOX_CYC_REQ;
    logic              VMA_READ;
    logic              VMA_WRITE;
    logic              VMA_PAUSE;
    logic              LOAD_AR;
    logic              LOAD_ARX;
    logic              VMA_FETCH;
    logic [ADDR_W-1:0] VMA;
    logic [35:0]       WR_DATA;
    logic              CLR_ERR;
    logic              MBOX_RESP;
    logic [35:0]       MB;
    logic              RESP_LOAD_AR;
    logic              RESP_LOAD_ARX;
    logic              RESP_FETCH;
    logic              MBOX_BUSY;
    logic              NXM_ERR;
    logic              OVERRUN_ERR;
    logic              MEM_REQ;
    logic              MEM_WE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [35:0]       MEM_WDATA;
    logic [35:0]       MEM_RDATA;
    logic              MEM_ACK;

    modport master (
        output MBOX_CYC_REQ, VMA_READ, VMA_WRITE, VMA_PAUSE, LOAD_AR, LOAD_ARX,
               VMA_FETCH, VMA, WR_DATA, CLR_ERR, MEM_RDATA, MEM_ACK,
        input  MBOX_RESP, MB, RESP_LOAD_AR, RESP_LOAD_ARX, RESP_FETCH, MBOX_BUSY,
               NXM_ERR, OVERRUN_ERR, MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA
    );

    modport slave (
        input  MBOX_CYC_REQ, VMA_READ, VMA_WRITE, VMA_PAUSE, LOAD_AR, LOAD_ARX,
               VMA_FETCH, VMA, WR_DATA, CLR_ERR, MEM_RDATA, MEM_ACK,
        output MBOX_RESP, MB, RESP_LOAD_AR, RESP_LOAD_ARX, RESP_FETCH, MBOX_BUSY,
               NXM_ERR, OVERRUN_ERR, MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA
    );
endinterface

// File: rtl/mbox_cyc_responder.sv
// MBOX cycle front end: runs read, write and read-pause-write cycles against a
// request/ack backing memory, with NXM timeout and overrun detection.
module mbox_cyc_responder #(
    parameter int ADDR_W  = 23,
    parameter int TIMEOUT = 64
) (
    input logic                 clk,
    input logic                 RESET,
    mbox_cyc_responder_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD, WR, RESP, PAUSE} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_d, req_state;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [35:0]       wdata_q, mb_q;
    logic              tag_ar_q, tag_arx_q, tag_fetch_q;
    logic              rpw_q, nxm_q, ovr_q;
    logic              busy, in_mem, accept, pause_wr, timeout, overrun;

    assign busy   = (state_q == RD) || (state_q == WR) || (state_q == RESP);
    assign in_mem = (state_q == RD) || (state_q == WR);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        pause_wr  = 1'b0;
        timeout   = 1'b0;
        overrun   = bus.MBOX_CYC_REQ && busy;
        req_state = RESP;
        if (bus.VMA_READ)
            req_state = RD;
        else if (bus.VMA_WRITE)
            req_state = WR;

        case (state_q)
            IDLE: begin
                if (bus.MBOX_CYC_REQ) begin
                    accept  = 1'b1;
                    state_d = req_state;
                end
            end
            PAUSE: begin
                // A write completes the RPW to the held address; anything else
                // abandons the pause and starts a fresh cycle.
                if (bus.MBOX_CYC_REQ && bus.VMA_WRITE) begin
                    pause_wr = 1'b1;
                    state_d  = WR;
                end else if (bus.MBOX_CYC_REQ) begin
                    accept  = 1'b1;
                    state_d = req_state;
                end
            end
            RD, WR: begin
                if (bus.MEM_ACK) begin
                    state_d = RESP;
                end else if (cnt_q == TO_LAST) begin
                    timeout = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = rpw_q ? PAUSE : IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d != state_q)
            cnt_d = '0;
        else if (in_mem && !bus.MEM_ACK)
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            mb_q        <= '0;
            tag_ar_q    <= 1'b0;
            tag_arx_q   <= 1'b0;
            tag_fetch_q <= 1'b0;
            rpw_q       <= 1'b0;
        end else begin
            if (accept || pause_wr) begin
                tag_ar_q    <= bus.LOAD_AR;
                tag_arx_q   <= bus.LOAD_ARX;
                tag_fetch_q <= bus.VMA_FETCH;
                if (bus.VMA_WRITE)
                    wdata_q <= bus.WR_DATA;
            end
            if (accept) begin
                addr_q <= bus.VMA;
                rpw_q  <= bus.VMA_READ && bus.VMA_PAUSE;
            end
            if (pause_wr || timeout)
                rpw_q <= 1'b0;
            if (state_q == RD && bus.MEM_ACK)
                mb_q <= bus.MEM_RDATA;
            else if (state_q == RD && timeout)
                mb_q <= '0;
        end
    end

    // Sticky flags: a set event in the same cycle overrides CLR_ERR.
    always_ff @(posedge clk) begin
        if (RESET) begin
            nxm_q <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            if (timeout)
                nxm_q <= 1'b1;
            else if (bus.CLR_ERR)
                nxm_q <= 1'b0;
            if (overrun)
                ovr_q <= 1'b1;
            else if (bus.CLR_ERR)
                ovr_q <= 1'b0;
        end
    end

    assign bus.MEM_REQ       = in_mem;
    assign bus.MEM_WE        = (state_q == WR);
    assign bus.MEM_ADDR      = addr_q;
    assign bus.MEM_WDATA     = wdata_q;
    assign bus.MBOX_RESP     = (state_q == RESP);
    assign bus.MB            = mb_q;
    assign bus.RESP_LOAD_AR  = (state_q == RESP) && tag_ar_q;
    assign bus.RESP_LOAD_ARX = (state_q == RESP) && tag_arx_q;
    assign bus.RESP_FETCH    = (state_q == RESP) && tag_fetch_q;
    assign bus.MBOX_BUSY     = busy;
    assign bus.NXM_ERR       = nxm_q;
    assign bus.OVERRUN_ERR   = ovr_q;
endmodule

// File: tb/tb_mbox_cyc_responder.sv
// Bench for mbox_cyc_responder: directed scenarios plus randomized cycles
// checked against a transaction-level memory model.
module tb_mbox_cyc_responder;
    localparam int ADDR_W  = 23;
    localparam int TIMEOUT = 8;

    logic clk   = 1'b0;
    logic RESET = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    mbox_cyc_responder_if #(.ADDR_W(ADDR_W)) bus ();

    mbox_cyc_responder #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_req();
        bus.MBOX_CYC_REQ = 1'b0;
        bus.VMA_READ     = 1'b0;
        bus.VMA_WRITE    = 1'b0;
        bus.VMA_PAUSE    = 1'b0;
        bus.LOAD_AR      = 1'b0;
        bus.LOAD_ARX     = 1'b0;
        bus.VMA_FETCH    = 1'b0;
    endtask

    task automatic set_req(input logic rd, input logic wr, input logic pa, input logic [2:0] tg,
                           input logic [22:0] vma, input logic [35:0] wd);
        bus.MBOX_CYC_REQ = 1'b1;
        bus.VMA_READ     = rd;
        bus.VMA_WRITE    = wr;
        bus.VMA_PAUSE    = pa;
        bus.LOAD_AR      = tg[0];
        bus.LOAD_ARX     = tg[1];
        bus.VMA_FETCH    = tg[2];
        bus.VMA          = vma;
        bus.WR_DATA      = wd;
    endtask

    // Request on edge 0; returns in cycle 1 with the request withdrawn.
    task automatic req_pulse(input logic rd, input logic wr, input logic pa, input logic [2:0] tg,
                             input logic [22:0] vma, input logic [35:0] wd);
        set_req(rd, wr, pa, tg, vma, wd);
        tick();
        clr_req();
    endtask

    task automatic test_reset();
        clr_req();
        bus.VMA = '0; bus.WR_DATA = '0; bus.CLR_ERR = 1'b0;
        bus.MEM_ACK = 1'b0; bus.MEM_RDATA = '0;
        RESET = 1'b1;
        tick(); tick();
        n_tests++;
        if ({bus.MBOX_RESP, bus.MBOX_BUSY, bus.MEM_REQ, bus.MEM_WE, bus.NXM_ERR, bus.OVERRUN_ERR} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 000000",
                {bus.MBOX_RESP, bus.MBOX_BUSY, bus.MEM_REQ, bus.MEM_WE, bus.NXM_ERR, bus.OVERRUN_ERR});
        end
        n_tests++;
        if (bus.MB !== 36'o0 || bus.MEM_ADDR !== 23'o0 || bus.MEM_WDATA !== 36'o0) begin
            n_fail++; $display("FAIL reset_data: MB=%o ADDR=%o WDATA=%o want 0", bus.MB, bus.MEM_ADDR, bus.MEM_WDATA);
        end
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_read();
        req_pulse(1, 0, 0, 3'b001, 23'o1234, 36'o0);
        n_tests++;
        if (bus.MEM_REQ !== 1'b1 || bus.MEM_WE !== 1'b0 || bus.MEM_ADDR !== 23'o1234) begin
            n_fail++; $display("FAIL read_req: REQ=%b WE=%b ADDR=%o want 1 0 1234", bus.MEM_REQ, bus.MEM_WE, bus.MEM_ADDR);
        end
        tick(); tick();
        n_tests++;
        if (bus.MBOX_RESP !== 1'b0) begin
            n_fail++; $display("FAIL read_early_resp: got %b want 0", bus.MBOX_RESP);
        end
        bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 36'o123456701234;
        tick();
        bus.MEM_ACK = 1'b0;
        n_tests++;
        if (bus.MBOX_RESP !== 1'b1 || bus.MB !== 36'o123456701234 || bus.RESP_LOAD_AR !== 1'b1 ||
            bus.RESP_LOAD_ARX !== 1'b0 || bus.MEM_REQ !== 1'b0) begin
            n_fail++; $display("FAIL read_resp: RESP=%b MB=%o AR=%b ARX=%b REQ=%b want 1 123456701234 1 0 0",
                bus.MBOX_RESP, bus.MB, bus.RESP_LOAD_AR, bus.RESP_LOAD_ARX, bus.MEM_REQ);
        end
        tick();
        n_tests++;
        if (bus.MBOX_BUSY !== 1'b0 || bus.MBOX_RESP !== 1'b0) begin
            n_fail++; $display("FAIL read_after: BUSY=%b RESP=%b want 0 0", bus.MBOX_BUSY, bus.MBOX_RESP);
        end
    endtask

    task automatic test_rpw();
        req_pulse(1, 0, 1, 3'b000, 23'o100, 36'o0);
        bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 36'o77;
        tick();
        bus.MEM_ACK = 1'b0;
        n_tests++;
        if (bus.MBOX_RESP !== 1'b1 || bus.MB !== 36'o77) begin
            n_fail++; $display("FAIL rpw_read: RESP=%b MB=%o want 1 77", bus.MBOX_RESP, bus.MB);
        end
        tick();
        repeat (10) tick();
        n_tests++;
        if (bus.MBOX_BUSY !== 1'b0 || bus.MEM_REQ !== 1'b0) begin
            n_fail++; $display("FAIL rpw_pause: BUSY=%b REQ=%b want 0 0", bus.MBOX_BUSY, bus.MEM_REQ);
        end
        req_pulse(0, 1, 0, 3'b000, 23'o777, 36'o5);
        n_tests++;
        if (bus.MEM_ADDR !== 23'o100 || bus.MEM_WE !== 1'b1 || bus.MEM_WDATA !== 36'o5 || bus.MEM_REQ !== 1'b1) begin
            n_fail++; $display("FAIL rpw_write: ADDR=%o WE=%b WDATA=%o REQ=%b want 100 1 5 1",
                bus.MEM_ADDR, bus.MEM_WE, bus.MEM_WDATA, bus.MEM_REQ);
        end
        bus.MEM_ACK = 1'b1;
        tick();
        bus.MEM_ACK = 1'b0;
        n_tests++;
        if (bus.MBOX_RESP !== 1'b1) begin
            n_fail++; $display("FAIL rpw_write_resp: got %b want 1", bus.MBOX_RESP);
        end
        tick();
    endtask

    task automatic test_timeout();
        req_pulse(1, 0, 0, 3'b000, 23'o55, 36'o0);
        repeat (TIMEOUT - 1) tick();
        n_tests++;
        if (bus.MBOX_RESP !== 1'b0 || bus.MEM_REQ !== 1'b1 || bus.NXM_ERR !== 1'b0) begin
            n_fail++; $display("FAIL timeout_early: RESP=%b REQ=%b NXM=%b want 0 1 0", bus.MBOX_RESP, bus.MEM_REQ, bus.NXM_ERR);
        end
        tick();
        n_tests++;
        if (bus.MBOX_RESP !== 1'b1 || bus.MB !== 36'o0 || bus.NXM_ERR !== 1'b1 || bus.MEM_REQ !== 1'b0) begin
            n_fail++; $display("FAIL timeout_resp: RESP=%b MB=%o NXM=%b REQ=%b want 1 0 1 0",
                bus.MBOX_RESP, bus.MB, bus.NXM_ERR, bus.MEM_REQ);
        end
        tick();
        bus.CLR_ERR = 1'b1;
        tick();
        bus.CLR_ERR = 1'b0;
        n_tests++;
        if (bus.NXM_ERR !== 1'b0) begin
            n_fail++; $display("FAIL timeout_clr: NXM=%b want 0", bus.NXM_ERR);
        end
        // A timed-out RPW read must not leave the pause pending.
        req_pulse(1, 0, 1, 3'b000, 23'o200, 36'o0);
        repeat (TIMEOUT) tick();
        tick();
        req_pulse(0, 1, 0, 3'b000, 23'o321, 36'o17);
        n_tests++;
        if (bus.MEM_ADDR !== 23'o321 || bus.MEM_WE !== 1'b1) begin
            n_fail++; $display("FAIL timeout_rpw_cancel: ADDR=%o WE=%b want 321 1", bus.MEM_ADDR, bus.MEM_WE);
        end
        bus.MEM_ACK = 1'b1; bus.CLR_ERR = 1'b1;
        tick();
        bus.MEM_ACK = 1'b0; bus.CLR_ERR = 1'b0;
        tick();
        n_tests++;
        if (bus.NXM_ERR !== 1'b0 || bus.MBOX_BUSY !== 1'b0) begin
            n_fail++; $display("FAIL timeout_end: NXM=%b BUSY=%b want 0 0", bus.NXM_ERR, bus.MBOX_BUSY);
        end
    endtask

    task automatic test_overrun();
        req_pulse(1, 0, 0, 3'b010, 23'o4321, 36'o0);
        set_req(0, 1, 0, 3'b001, 23'o7777, 36'o1);
        tick();
        clr_req();
        n_tests++;
        if (bus.OVERRUN_ERR !== 1'b1 || bus.MEM_ADDR !== 23'o4321 || bus.MEM_WE !== 1'b0 || bus.MEM_REQ !== 1'b1) begin
            n_fail++; $display("FAIL overrun_rd: OVR=%b ADDR=%o WE=%b REQ=%b want 1 4321 0 1",
                bus.OVERRUN_ERR, bus.MEM_ADDR, bus.MEM_WE, bus.MEM_REQ);
        end
        bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 36'o765432101234; bus.CLR_ERR = 1'b1;
        tick();
        bus.MEM_ACK = 1'b0; bus.CLR_ERR = 1'b0;
        n_tests++;
        if (bus.MBOX_RESP !== 1'b1 || bus.MB !== 36'o765432101234 || bus.RESP_LOAD_ARX !== 1'b1 ||
            bus.RESP_LOAD_AR !== 1'b0 || bus.OVERRUN_ERR !== 1'b0) begin
            n_fail++; $display("FAIL overrun_complete: RESP=%b MB=%o ARX=%b AR=%b OVR=%b want 1 765432101234 1 0 0",
                bus.MBOX_RESP, bus.MB, bus.RESP_LOAD_ARX, bus.RESP_LOAD_AR, bus.OVERRUN_ERR);
        end
        // Request coincident with MBOX_RESP, with CLR_ERR also asserted: set wins.
        set_req(1, 0, 0, 3'b000, 23'o11, 36'o0);
        bus.CLR_ERR = 1'b1;
        tick();
        clr_req();
        bus.CLR_ERR = 1'b0;
        n_tests++;
        if (bus.OVERRUN_ERR !== 1'b1 || bus.MEM_REQ !== 1'b0 || bus.MBOX_BUSY !== 1'b0) begin
            n_fail++; $display("FAIL overrun_resp: OVR=%b REQ=%b BUSY=%b want 1 0 0",
                bus.OVERRUN_ERR, bus.MEM_REQ, bus.MBOX_BUSY);
        end
        bus.CLR_ERR = 1'b1;
        tick();
        bus.CLR_ERR = 1'b0;
        n_tests++;
        if (bus.OVERRUN_ERR !== 1'b0) begin
            n_fail++; $display("FAIL overrun_clr: OVR=%b want 0", bus.OVERRUN_ERR);
        end
    endtask

    task automatic test_reset_mid();
        req_pulse(1, 0, 0, 3'b000, 23'o600, 36'o0);
        tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        n_tests++;
        if (bus.MEM_REQ !== 1'b0 || bus.MBOX_RESP !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid: REQ=%b RESP=%b want 0 0", bus.MEM_REQ, bus.MBOX_RESP);
        end
        bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 36'o111;
        tick();
        bus.MEM_ACK = 1'b0;
        tick();
        n_tests++;
        if (bus.MBOX_RESP !== 1'b0 || bus.MB !== 36'o0 || bus.MBOX_BUSY !== 1'b0) begin
            n_fail++; $display("FAIL reset_stray_ack: RESP=%b MB=%o BUSY=%b want 0 0 0", bus.MBOX_RESP, bus.MB, bus.MBOX_BUSY);
        end
        req_pulse(1, 0, 0, 3'b100, 23'o601, 36'o0);
        bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 36'o222;
        tick();
        bus.MEM_ACK = 1'b0;
        n_tests++;
        if (bus.MBOX_RESP !== 1'b1 || bus.MB !== 36'o222 || bus.RESP_FETCH !== 1'b1) begin
            n_fail++; $display("FAIL reset_fresh_read: RESP=%b MB=%o FETCH=%b want 1 222 1", bus.MBOX_RESP, bus.MB, bus.RESP_FETCH);
        end
        tick();
    endtask

    task automatic test_null_write();
        req_pulse(0, 0, 0, 3'b001, 23'o3, 36'o0);
        n_tests++;
        if (bus.MBOX_RESP !== 1'b1 || bus.MEM_REQ !== 1'b0 || bus.MB !== 36'o222 || bus.RESP_LOAD_AR !== 1'b1) begin
            n_fail++; $display("FAIL null_resp: RESP=%b REQ=%b MB=%o AR=%b want 1 0 222 1",
                bus.MBOX_RESP, bus.MEM_REQ, bus.MB, bus.RESP_LOAD_AR);
        end
        tick();
        n_tests++;
        if (bus.MBOX_RESP !== 1'b0 || bus.MBOX_BUSY !== 1'b0) begin
            n_fail++; $display("FAIL null_after: RESP=%b BUSY=%b want 0 0", bus.MBOX_RESP, bus.MBOX_BUSY);
        end
        req_pulse(0, 1, 1, 3'b000, 23'o1357, 36'o7070);
        n_tests++;
        if (bus.MEM_WE !== 1'b1 || bus.MEM_ADDR !== 23'o1357 || bus.MEM_WDATA !== 36'o7070) begin
            n_fail++; $display("FAIL write_req: WE=%b ADDR=%o WDATA=%o want 1 1357 7070", bus.MEM_WE, bus.MEM_ADDR, bus.MEM_WDATA);
        end
        bus.MEM_ACK = 1'b1;
        tick();
        bus.MEM_ACK = 1'b0;
        n_tests++;
        if (bus.MBOX_RESP !== 1'b1 || bus.MB !== 36'o222) begin
            n_fail++; $display("FAIL write_resp: RESP=%b MB=%o want 1 222", bus.MBOX_RESP, bus.MB);
        end
        tick();
        req_pulse(0, 1, 0, 3'b000, 23'o2460, 36'o3);
        n_tests++;
        if (bus.MEM_ADDR !== 23'o2460 || bus.MEM_WDATA !== 36'o3) begin
            n_fail++; $display("FAIL write_not_pause: ADDR=%o WDATA=%o want 2460 3", bus.MEM_ADDR, bus.MEM_WDATA);
        end
        bus.MEM_ACK = 1'b1;
        tick();
        bus.MEM_ACK = 1'b0;
        tick();
    endtask

    // Randomized cycles: the memory array seen by the DUT is updated only from
    // what it drives on the memory port; the reference array from the intent.
    task automatic test_random();
        logic [35:0] ref_mem [8];
        logic [35:0] bmem [8];
        logic [35:0] exp_mb, wd;
        logic [22:0] a, held;
        logic [2:0]  tg;
        logic        pa;
        int          op, d;
        for (int i = 0; i < 8; i++) begin
            ref_mem[i] = 36'(i) * 36'o1001 + 36'o7;
            bmem[i]    = ref_mem[i];
        end
        exp_mb = '0;
        for (int t = 0; t < 60; t++) begin
            op = (t == 0) ? 0 : int'($urandom_range(0, 3));
            a  = 23'($urandom);
            wd = 36'({$urandom, $urandom});
            tg = 3'($urandom);
            pa = (op == 3) || ((op == 1 || op == 2) && $urandom_range(0, 1) == 1);
            req_pulse(op == 0 || op == 3, op == 1, pa, tg, a, wd);
            if (op == 2) begin
                n_tests++;
                if (bus.MBOX_RESP !== 1'b1 || bus.MEM_REQ !== 1'b0 || bus.MB !== exp_mb) begin
                    n_fail++; $display("FAIL rnd_null t=%0d: RESP=%b REQ=%b MB=%o want 1 0 %o",
                        t, bus.MBOX_RESP, bus.MEM_REQ, bus.MB, exp_mb);
                end
            end else begin
                d = int'($urandom_range(1, 6));
                repeat (d - 1) tick();
                n_tests++;
                if (bus.MEM_REQ !== 1'b1 || bus.MEM_WE !== (op == 1) || bus.MEM_ADDR !== a || bus.MBOX_RESP !== 1'b0) begin
                    n_fail++; $display("FAIL rnd_req t=%0d: REQ=%b WE=%b ADDR=%o RESP=%b want 1 %b %o 0",
                        t, bus.MEM_REQ, bus.MEM_WE, bus.MEM_ADDR, bus.MBOX_RESP, op == 1, a);
                end
                bus.MEM_ACK   = 1'b1;
                bus.MEM_RDATA = bmem[bus.MEM_ADDR[2:0]];
                if (bus.MEM_WE) bmem[bus.MEM_ADDR[2:0]] = bus.MEM_WDATA;
                tick();
                bus.MEM_ACK = 1'b0;
                if (op == 1) ref_mem[a[2:0]] = wd;
                else         exp_mb = ref_mem[a[2:0]];
                n_tests++;
                if (bus.MBOX_RESP !== 1'b1 || bus.MEM_REQ !== 1'b0 || bus.MB !== exp_mb) begin
                    n_fail++; $display("FAIL rnd_resp t=%0d: RESP=%b REQ=%b MB=%o want 1 0 %o",
                        t, bus.MBOX_RESP, bus.MEM_REQ, bus.MB, exp_mb);
                end
            end
            n_tests++;
            if ({bus.RESP_FETCH, bus.RESP_LOAD_ARX, bus.RESP_LOAD_AR} !== tg) begin
                n_fail++; $display("FAIL rnd_tags t=%0d: got %b want %b", t,
                    {bus.RESP_FETCH, bus.RESP_LOAD_ARX, bus.RESP_LOAD_AR}, tg);
            end
            if (op == 3) begin
                tick();
                repeat ($urandom_range(0, 3)) tick();
                n_tests++;
                if (bus.MBOX_BUSY !== 1'b0 || bus.MBOX_RESP !== 1'b0) begin
                    n_fail++; $display("FAIL rnd_pause t=%0d: BUSY=%b RESP=%b want 0 0", t, bus.MBOX_BUSY, bus.MBOX_RESP);
                end
                held = a;
                a    = 23'($urandom);
                wd   = 36'({$urandom, $urandom});
                tg   = 3'($urandom);
                req_pulse(0, 1, 0, tg, a, wd);
                n_tests++;
                if (bus.MEM_ADDR !== held || bus.MEM_WE !== 1'b1 || bus.MEM_WDATA !== wd) begin
                    n_fail++; $display("FAIL rnd_rpw_wr t=%0d: ADDR=%o WE=%b WDATA=%o want %o 1 %o",
                        t, bus.MEM_ADDR, bus.MEM_WE, bus.MEM_WDATA, held, wd);
                end
                repeat (int'($urandom_range(0, 4))) tick();
                bus.MEM_ACK = 1'b1;
                if (bus.MEM_WE) bmem[bus.MEM_ADDR[2:0]] = bus.MEM_WDATA;
                tick();
                bus.MEM_ACK = 1'b0;
                ref_mem[held[2:0]] = wd;
                n_tests++;
                if (bus.MBOX_RESP !== 1'b1 || {bus.RESP_FETCH, bus.RESP_LOAD_ARX, bus.RESP_LOAD_AR} !== tg) begin
                    n_fail++; $display("FAIL rnd_rpw_resp t=%0d: RESP=%b tags=%b want 1 %b", t, bus.MBOX_RESP,
                        {bus.RESP_FETCH, bus.RESP_LOAD_ARX, bus.RESP_LOAD_AR}, tg);
                end
            end
            tick();
            n_tests++;
            if (bus.MBOX_BUSY !== 1'b0 || bus.MBOX_RESP !== 1'b0) begin
                n_fail++; $display("FAIL rnd_idle t=%0d: BUSY=%b RESP=%b want 0 0", t, bus.MBOX_BUSY, bus.MBOX_RESP);
            end
        end
        n_tests++;
        if (bus.OVERRUN_ERR !== 1'b0 || bus.NXM_ERR !== 1'b0) begin
            n_fail++; $display("FAIL rnd_flags: OVR=%b NXM=%b want 0 0", bus.OVERRUN_ERR, bus.NXM_ERR);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_rpw();
        test_timeout();
        test_overrun();
        test_reset_mid();
        test_null_write();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
